xcorr_win_ctrl: RTL

Sliding-window sequencer for the cross-correlator sample buffer. It writes each incoming Rx sample into a single-clock dual-port BRAM used as a circular buffer. Once WIN_LEN samples are held, every accepted sample triggers a burst of WIN_LEN reads, newest to oldest. The block sits between the Rx sample stream and the correlator MAC pipeline and owns both BRAM ports.

---
 rtl/xcorr_win_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xcorr_win_ctrl.sv
// Sliding-window sequencer: writes Rx samples into a circular BRAM and, once a full
// window is held, reads the window back newest-to-oldest for the correlator MAC.
module xcorr_win_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int WIN_LEN    = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [DATA_WIDTH-1:0]      s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    output logic [DATA_WIDTH-1:0]      bram_wr_data,
    output logic                       bram_wr_valid,
    output logic [$clog2(DEPTH)-1:0]   bram_wr_addr,
    output logic                       bram_rd_valid,
    output logic [$clog2(DEPTH)-1:0]   bram_rd_addr,
    input  logic [DATA_WIDTH-1:0]      bram_rd_data,
    output logic [DATA_WIDTH-1:0]      m_data,
    output logic                       m_valid,
    output logic [$clog2(WIN_LEN)-1:0] m_tap,
    output logic                       m_first,
    output logic                       m_last,
    output logic                       win_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(WIN_LEN);
    localparam int CW = $clog2(WIN_LEN + 1);

    localparam logic [CW-1:0] WIN_CNT   = CW'(WIN_LEN);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [TW-1:0] LAST_TAP  = TW'(WIN_LEN - 1);
    localparam logic [AW:0]   DEPTH_EXT = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] nptr;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tap;

    logic          hs;
    logic [CW-1:0] cnt_inc;
    logic [AW:0]   tap_ext;
    logic [AW:0]   nptr_ext;
    logic [AW:0]   rd_addr_ext;

    // s_ready is gated by rst_n so the port reads 0 while reset is held
    assign s_ready       = rst_n && enable && (state == IDLE);
    assign hs            = s_valid && s_ready;
    assign bram_wr_valid = hs;
    assign bram_wr_addr  = hs ? wr_ptr : '0;
    assign bram_wr_data  = hs ? s_data : '0;
    assign bram_rd_valid = (state == BURST);
    assign bram_rd_addr  = rd_addr_ext[AW-1:0];

    assign cnt_inc  = (cnt == WIN_CNT) ? WIN_CNT : cnt + CW'(1);
    assign tap_ext  = (AW + 1)'(tap);
    assign nptr_ext = {1'b0, nptr};

    // Modulo-DEPTH subtraction without a divider, so DEPTH need not be a power of two
    always_comb begin
        rd_addr_ext = '0;
        if (state == BURST) begin
            if (tap_ext <= nptr_ext)
                rd_addr_ext = nptr_ext - tap_ext;
            else
                rd_addr_ext = nptr_ext + DEPTH_EXT - tap_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            nptr    <= '0;
            cnt     <= '0;
            tap     <= '0;
            m_valid <= 1'b0;
            m_tap   <= '0;
        end else begin
            m_valid <= bram_rd_valid;
            m_tap   <= bram_rd_valid ? tap : '0;
            if (flush)
                cnt <= '0;
            case (state)
                IDLE: begin
                    if (hs) begin
                        wr_ptr <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
                        nptr   <= wr_ptr;
                        // A flush landing on a handshake keeps just this sample
                        if (flush) begin
                            cnt <= CW'(1);
                        end else begin
                            cnt <= cnt_inc;
                            if (cnt_inc == WIN_CNT) begin
                                state <= BURST;
                                tap   <= '0;
                            end
                        end
                    end
                end
                BURST: begin
                    if (tap == LAST_TAP)
                        state <= DRAIN;
                    else
                        tap <= tap + TW'(1);
                end
                DRAIN: begin
                    state <= IDLE;
                    tap   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign m_data   = m_valid ? bram_rd_data : '0;
    assign m_first  = m_valid && (m_tap == '0);
    assign m_last   = m_valid && (m_tap == LAST_TAP);
    assign win_full = (cnt == WIN_CNT);

endmodule
